// File: rtl/truth_table_sweeper_if.sv
// Bus between a truth-table sweeper and its controller / device under test.
//   start, abort     : sweep control (controller -> sweeper)
//   expected[7:0]    : expected truth table, latched by the sweeper at sweep start
//   y                : response of the combinational block under test
//   a, b, c          : stimulus vector; a is the MSB of the 3-bit index
//   busy, done       : sweeper status
//   pass, fail_idx   : comparison result, meaningful while done is high
//   captured[7:0]    : measured truth table
interface truth_table_sweeper_if;
    logic       start;
    logic       abort;
    logic [7:0] expected;
    logic       y;
    logic       a;
    logic       b;
    logic       c;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] captured;
    logic [2:0] fail_idx;

    // Controller side: drives control, expected table and the DUT response.
    modport master (
        output start, abort, expected, y,
        input  a, b, c, busy, done, pass, captured, fail_idx
    );

    // Sweeper side.
    modport slave (
        input  start, abort, expected, y,
        output a, b, c, busy, done, pass, captured, fail_idx
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Sweeps all eight {a,b,c} vectors into a 3-input combinational block, holds
// each for SETTLE_CYCLES cycles, samples y at the end of the hold, and compares
// the measured truth table against an expected one latched at sweep start.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : truth_table_sweeper_if.slave (control, stimulus, response, result)
module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    truth_table_sweeper_if.slave  bus
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned TT_W  = 8;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TT_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] abc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [TT_W-1:0]  captured_q;
    logic [TT_W-1:0]  expected_q;
    logic             busy_q;
    logic             done_q;

    logic [TT_W-1:0]  mismatch_c;
    logic [IDX_W-1:0] first_mismatch_c;

    // Sweep controller: state, stimulus index, settle counter and capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            abc_q      <= '0;
            cnt_q      <= '0;
            captured_q <= '0;
            expected_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        expected_q <= bus.expected;
                        captured_q <= '0;
                        idx_q      <= '0;
                        abc_q      <= '0;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        state_q    <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    // Abort wins over a sample due on the same edge.
                    if (bus.abort) begin
                        idx_q   <= '0;
                        abc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        captured_q[idx_q] <= bus.y;
                        if (idx_q == IDX_LAST) begin
                            // Last vector stays on the pins through DONE.
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                            abc_q <= idx_q + IDX_W'(1);
                            cnt_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Lowest mismatching index: scan downward so the lowest hit is written last.
    always_comb begin
        mismatch_c       = captured_q ^ expected_q;
        first_mismatch_c = '0;
        for (int i = TT_W - 1; i >= 0; i--) begin
            if (mismatch_c[i]) begin
                first_mismatch_c = IDX_W'(i);
            end
        end
    end

    assign bus.a        = abc_q[2];
    assign bus.b        = abc_q[1];
    assign bus.c        = abc_q[0];
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.captured = captured_q;
    assign bus.pass     = done_q && (mismatch_c == '0);
    assign bus.fail_idx = (done_q && (mismatch_c != '0)) ? first_mismatch_c : '0;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: one instance with SETTLE_CYCLES=4
// driving y=(a&b)|c, one with SETTLE_CYCLES=1 driving y=a^b^c.
module tb_truth_table_sweeper;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    truth_table_sweeper_if if4 ();
    truth_table_sweeper_if if1 ();

    // Block-under-test models.
    assign if4.y = (if4.a & if4.b) | if4.c;
    assign if1.y = if1.a ^ if1.b ^ if1.c;

    truth_table_sweeper #(.SETTLE_CYCLES(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full SETTLE_CYCLES=4 sweep; optionally holds start high throughout and
    // optionally rewrites the expected input mid-sweep.
    task automatic sweep4(input logic [7:0] exp, input bit hold_start, input bit scribble);
        if4.expected = exp;
        if4.start    = 1'b1;
        tick();
        if (!hold_start) if4.start = 1'b0;
        for (int v = 0; v < 8; v++) begin
            check($sformatf("abc_v%0d", v), 8'({if4.a, if4.b, if4.c}), 8'(v));
            check($sformatf("busy_v%0d", v), 8'(if4.busy), 8'd1);
            if (scribble && v == 2) if4.expected = 8'h00;
            repeat (4) tick();
        end
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        rst_n        = 1'b0;
        if4.start    = 1'b0;
        if4.abort    = 1'b0;
        if4.expected = 8'h00;
        if1.start    = 1'b0;
        if1.abort    = 1'b0;
        if1.expected = 8'h00;

        // Reset, with start held high: must be ignored.
        if4.start = 1'b1;
        tick();
        tick();
        if4.start = 1'b0;
        check("rst_busy", 8'(if4.busy), 8'd0);
        check("rst_done", 8'(if4.done), 8'd0);
        check("rst_abc", 8'({if4.a, if4.b, if4.c}), 8'd0);
        check("rst_captured", if4.captured, 8'h00);
        check("rst_pass", 8'(if4.pass), 8'd0);
        check("rst_fail_idx", 8'(if4.fail_idx), 8'd0);
        rst_n = 1'b1;
        tick();
        check("idle_busy", 8'(if4.busy), 8'd0);

        // Matching sweep; expected input scribbled mid-sweep must not matter.
        sweep4(8'hEA, 1'b0, 1'b1);
        check("ea_done", 8'(if4.done), 8'd1);
        check("ea_busy", 8'(if4.busy), 8'd0);
        check("ea_abc", 8'({if4.a, if4.b, if4.c}), 8'd7);
        check("ea_captured", if4.captured, 8'hEA);
        check("ea_pass", 8'(if4.pass), 8'd1);
        check("ea_fail_idx", 8'(if4.fail_idx), 8'd0);

        // Abort in DONE is ignored; DONE persists.
        if4.abort = 1'b1;
        repeat (3) tick();
        if4.abort = 1'b0;
        check("done_abort_done", 8'(if4.done), 8'd1);
        check("done_abort_captured", if4.captured, 8'hEA);
        check("done_abort_pass", 8'(if4.pass), 8'd1);

        // Mismatch at bit 0.
        sweep4(8'hEB, 1'b0, 1'b0);
        check("eb_done", 8'(if4.done), 8'd1);
        check("eb_captured", if4.captured, 8'hEA);
        check("eb_pass", 8'(if4.pass), 8'd0);
        check("eb_fail_idx", 8'(if4.fail_idx), 8'd0);

        // Mismatch at bit 6 only.
        sweep4(8'hAA, 1'b0, 1'b0);
        check("aa_pass", 8'(if4.pass), 8'd0);
        check("aa_fail_idx", 8'(if4.fail_idx), 8'd6);

        // Abort on the edge that would sample idx=3 (16th edge after start).
        if4.expected = 8'hEA;
        if4.start    = 1'b1;
        tick();
        if4.start = 1'b0;
        repeat (15) tick();
        check("pre_abort_abc", 8'({if4.a, if4.b, if4.c}), 8'd3);
        if4.abort = 1'b1;
        tick();
        if4.abort = 1'b0;
        check("abort_busy", 8'(if4.busy), 8'd0);
        check("abort_done", 8'(if4.done), 8'd0);
        check("abort_abc", 8'({if4.a, if4.b, if4.c}), 8'd0);
        check("abort_captured", if4.captured, 8'h02);
        check("abort_pass", 8'(if4.pass), 8'd0);
        repeat (5) tick();
        check("abort_stays_idle", 8'(if4.busy), 8'd0);

        // Reset mid-sweep while idx=5.
        if4.start = 1'b1;
        tick();
        if4.start = 1'b0;
        repeat (22) tick();
        check("pre_rst_abc", 8'({if4.a, if4.b, if4.c}), 8'd5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_busy", 8'(if4.busy), 8'd0);
        check("midrst_done", 8'(if4.done), 8'd0);
        check("midrst_abc", 8'({if4.a, if4.b, if4.c}), 8'd0);
        check("midrst_captured", if4.captured, 8'h00);
        check("midrst_fail_idx", 8'(if4.fail_idx), 8'd0);
        sweep4(8'hEA, 1'b0, 1'b0);
        check("postrst_captured", if4.captured, 8'hEA);
        check("postrst_pass", 8'(if4.pass), 8'd1);

        // Start held high through the sweep, then into DONE: immediate restart.
        sweep4(8'hEB, 1'b1, 1'b0);
        check("hold_done", 8'(if4.done), 8'd1);
        check("hold_fail_idx", 8'(if4.fail_idx), 8'd0);
        if4.expected = 8'hEA;
        tick();
        if4.start = 1'b0;
        check("restart_busy", 8'(if4.busy), 8'd1);
        check("restart_done", 8'(if4.done), 8'd0);
        check("restart_captured", if4.captured, 8'h00);
        repeat (3) tick();
        check("restart_abc_hold", 8'({if4.a, if4.b, if4.c}), 8'd0);
        tick();
        check("restart_abc_step", 8'({if4.a, if4.b, if4.c}), 8'd1);
        repeat (28) tick();
        check("restart_pass", 8'(if4.pass), 8'd1);

        // SETTLE_CYCLES=1: one vector per edge, DONE eight edges after start.
        if1.expected = 8'h96;
        if1.start    = 1'b1;
        tick();
        if1.start = 1'b0;
        for (int v = 0; v < 7; v++) begin
            check($sformatf("sc1_abc_v%0d", v), 8'({if1.a, if1.b, if1.c}), 8'(v));
            tick();
        end
        check("sc1_abc_v7", 8'({if1.a, if1.b, if1.c}), 8'd7);
        check("sc1_not_done_yet", 8'(if1.done), 8'd0);
        tick();
        check("sc1_done", 8'(if1.done), 8'd1);
        check("sc1_captured", if1.captured, 8'h96);
        check("sc1_pass", 8'(if1.pass), 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
